// File: rtl/si_resize_serializer_if.sv
// Handshake bundle for the resize serializer.
// One word in, N_CH widened lanes out.
interface si_resize_serializer_if #(
  parameter int N_IN    = 8,
  parameter int N_OUT   = 32,
  parameter int N_CH    = 4,
  parameter int SHIFT_W = 5,
  parameter int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
);
  logic                 in_valid;
  logic                 in_ready;
  logic [N_CH*N_IN-1:0] in_data;
  logic                 in_signed;
  logic [SHIFT_W-1:0]   in_shift;
  logic                 out_valid;
  logic                 out_ready;
  logic [N_OUT-1:0]     out_data;
  logic [CH_W-1:0]      out_ch;
  logic                 out_last;

  modport master (
    output in_valid, in_data, in_signed, in_shift,
    output out_ready,
    input  in_ready,
    input  out_valid, out_data, out_ch, out_last
  );

  modport slave (
    input  in_valid, in_data, in_signed, in_shift,
    input  out_ready,
    output in_ready,
    output out_valid, out_data, out_ch, out_last
  );
endinterface

// File: rtl/si_resize_serializer.sv
// Packed-lane serializer: each lane is sign/zero
// extended to N_OUT bits and left-shifted.
module si_resize_serializer #(
  parameter int N_IN    = 8,
  parameter int N_OUT   = 32,
  parameter int N_CH    = 4,
  parameter int SHIFT_W = 5
) (
  input logic                 clk,
  input logic                 rst,
  si_resize_serializer_if.slave bus
);
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int MAX_SH = N_OUT - N_IN;
  localparam logic [CH_W-1:0] LAST = CH_W'(N_CH - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state_q, state_d;
  logic [CH_W-1:0]      lane_q, lane_d;
  logic [N_CH*N_IN-1:0] word_q;
  logic                 sgn_q;
  logic [SHIFT_W-1:0]   sh_q, sh_in;
  logic                 load;
  logic                 busy, is_last, out_fire;
  logic [N_IN-1:0]      lanes [N_CH];
  logic [N_IN-1:0]      cur;
  logic [N_OUT-1:0]     ext;

  assign busy     = (state_q == BUSY);
  assign is_last  = (lane_q == LAST);
  assign out_fire = busy && bus.out_ready;

  assign bus.in_ready  = !busy || (out_fire && is_last);
  assign bus.out_valid = busy;
  assign bus.out_last  = busy && is_last;
  assign bus.out_ch    = busy ? lane_q : '0;
  assign bus.out_data  = busy ? (ext << sh_q) : '0;

  // Clamp so no significant bit can be shifted out.
  always_comb begin
    sh_in = bus.in_shift;
    if (32'(bus.in_shift) > MAX_SH)
      sh_in = SHIFT_W'(MAX_SH);
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    assign lanes[k] = word_q[k*N_IN +: N_IN];
  end

  assign cur = lanes[lane_q];

  if (N_OUT > N_IN) begin : g_ext
    assign ext = {{(N_OUT-N_IN){sgn_q & cur[N_IN-1]}}, cur};
  end else begin : g_pass
    assign ext = cur;
  end

  // Next-state: walk lanes, reload on the last beat.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          load    = 1'b1;
          lane_d  = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (out_fire) begin
          if (!is_last) begin
            lane_d = lane_q + CH_W'(1);
          end else if (bus.in_valid) begin
            load   = 1'b1;
            lane_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, lane index and held word registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lane_q  <= '0;
      word_q  <= '0;
      sgn_q   <= 1'b0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      if (load) begin
        word_q <= bus.in_data;
        sgn_q  <= bus.in_signed;
        sh_q   <= sh_in;
      end
    end
  end
endmodule

// File: tb/tb_si_resize_serializer.sv
// Directed bench for si_resize_serializer
// with hand-computed expected lanes.
module tb_si_resize_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  si_resize_serializer_if #(
    .N_IN(8), .N_OUT(32), .N_CH(4), .SHIFT_W(5)
  ) bus ();

  si_resize_serializer #(
    .N_IN(8), .N_OUT(32), .N_CH(4), .SHIFT_W(5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [31:0] d, logic s, logic [4:0] sh);
    int n;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_signed = s;
    bus.in_shift  = sh;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) chk("send_timeout", 32'd1, 32'd0);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic lane_chk(string t, int k, logic [31:0] e);
    chk({t, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({t, "_data"}, bus.out_data, e);
    chk({t, "_ch"}, 32'(bus.out_ch), 32'(k));
    chk({t, "_last"}, 32'(bus.out_last), 32'(k == 3));
  endtask

  task automatic expect_word(string t, int from,
      logic [31:0] e0, logic [31:0] e1,
      logic [31:0] e2, logic [31:0] e3);
    logic [31:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int k = from; k < 4; k++) begin
      lane_chk($sformatf("%s_l%0d", t, k), k, e[k]);
      step();
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_signed = 1'b0;
    bus.in_shift  = '0;
    bus.out_ready = 1'b1;
    step();
    step();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data", bus.out_data, 32'd0);
    chk("rst_ch", 32'(bus.out_ch), 32'd0);
    chk("rst_last", 32'(bus.out_last), 32'd0);
    rst = 1'b0;
    step();
    chk("rst_ready", 32'(bus.in_ready), 32'd1);

    send(32'h807FFF01, 1'b1, 5'd0);
    expect_word("sgn", 0, 32'h00000001, 32'hFFFFFFFF,
                32'h0000007F, 32'hFFFFFF80);
    chk("idle_valid", 32'(bus.out_valid), 32'd0);

    send(32'h807FFF01, 1'b0, 5'd0);
    expect_word("uns", 0, 32'h00000001, 32'h000000FF,
                32'h0000007F, 32'h00000080);

    send(32'h807FFF01, 1'b1, 5'd4);
    expect_word("sh4", 0, 32'h00000010, 32'hFFFFFFF0,
                32'h000007F0, 32'hFFFFF800);

    send(32'h807FFF01, 1'b1, 5'd31);
    expect_word("clamp", 0, 32'h01000000, 32'hFF000000,
                32'h7F000000, 32'h80000000);

    send(32'h807FFF01, 1'b1, 5'd0);
    lane_chk("bp_l0", 0, 32'h00000001);
    step();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("bp_hold%0d_data", i), bus.out_data, 32'hFFFFFFFF);
      chk($sformatf("bp_hold%0d_ch", i), 32'(bus.out_ch), 32'd1);
      chk($sformatf("bp_hold%0d_rdy", i), 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    expect_word("bp", 1, 32'h0, 32'hFFFFFFFF,
                32'h0000007F, 32'hFFFFFF80);
    chk("bp_idle", 32'(bus.out_valid), 32'd0);

    send(32'h807FFF01, 1'b1, 5'd0);
    expect_word("b2b_a", 0, 32'h00000001, 32'hFFFFFFFF,
                32'h0000007F, 32'hFFFFFF80);
    // Note: above stepped past lane 3; redo with overlap.
    send(32'h807FFF01, 1'b1, 5'd0);
    for (int k = 0; k < 3; k++) step();
    lane_chk("b2b_l3", 3, 32'hFFFFFF80);
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h00000002;
    bus.in_signed = 1'b0;
    bus.in_shift  = 5'd0;
    #1;
    chk("b2b_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    expect_word("b2b_b", 0, 32'h00000002, 32'h0,
                32'h0, 32'h0);
    chk("b2b_idle", 32'(bus.out_valid), 32'd0);

    send(32'h807FFF01, 1'b1, 5'd0);
    step();
    step();
    lane_chk("mid_l2", 2, 32'h0000007F);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_data", bus.out_data, 32'd0);
    step();
    #2;
    rst = 1'b0;
    step();
    chk("mid_ready", 32'(bus.in_ready), 32'd1);
    send(32'h04030201, 1'b0, 5'd1);
    expect_word("post", 0, 32'h00000002, 32'h00000004,
                32'h00000006, 32'h00000008);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
